mac_sequencer: RTL
==================

Name: mac_sequencer

Overview:
Command-driven controller that sequences one MacUnit through a vector operation.
- Accepts a command (op, length, base addresses) and issues reads to the x and w operand memories.
- Drives the MacUnit control strobes aligned to the memory read latency, then presents the result with a valid/ready handshake.
- Sits between the layer scheduler (command side) and the MacUnit/operand-memory pair (datapath side).

Parameters:
ADDR_W, 10, operand memory address width; addresses wrap modulo 2^ADDR_W
LEN_W, 10, command length width; max vector length 2^LEN_W-1
RD_LATENCY, 1, cycles from rd_en/addr to data on the MacUnit x/w buses; legal 1..4

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  high only in IDLE
cmd_op  input  1  0 = DOT (sum x[i]*w[i]); 1 = SCALED (k*sum of x, k = first x word)
cmd_len  input  LEN_W  number of products N
cmd_x_base  input  ADDR_W  x memory base address
cmd_w_base  input  ADDR_W  w memory base address (ignored for SCALED)
x_rd_en  output  1  x memory read strobe
x_addr  output  ADDR_W  x memory read address
w_rd_en  output  1  w memory read strobe
w_addr  output  ADDR_W  w memory read address
mac_reg_enable  output  1  to MacUnit
mac_x_select  output  1  to MacUnit
mac_w_select  output  1  to MacUnit
mac_acc_loopback  output  1  to MacUnit
mac_acc_update  output  1  to MacUnit
res_valid  output  1  MacUnit acc holds the final result
res_empty  output  1  qualifies res_valid; command had N = 0, acc untouched
res_ready  input  1  result consumed
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0 except cmd_ready = 1. FSM enters IDLE, counters clear, the in-flight read pipeline is flushed. Reset mid-command abandons the command silently.
- All outputs are registered.
- States and transitions:
  - IDLE: on cmd_valid & cmd_ready, latch the command. N = 0 goes to DONE with res_empty = 1. Otherwise op = 0 goes to ISSUE, op = 1 goes to LOAD_K.
  - LOAD_K (1 cycle): x_rd_en = 1, x_addr = x_base. Next state is ISSUE with element pointer x_base+1.
  - ISSUE (N cycles): x_rd_en = 1 with x_addr incrementing from its start.
    - DOT: w_rd_en = 1, w_addr = w_base + i.
    - SCALED: w_rd_en = 0.
  - DRAIN (RD_LATENCY cycles): no reads; waits for the last product.
  - DONE: res_valid = 1, all mac strobes 0 so acc is held. Leave for IDLE on res_ready. res_empty is held with res_valid.
- Strobe alignment: a tag pipeline of depth RD_LATENCY carries {valid, first, kload} per read. At the pipe output:
  - kload: mac_reg_enable = 1.
  - Product element, DOT: mac_x_select = 1, mac_w_select = 1, mac_acc_update = 1.
  - Product element, SCALED: mac_x_select = 0, mac_w_select = 0 (mac_reg*x), mac_acc_update = 1.
  - mac_acc_loopback = 0 on the first element (restarts the accumulation without reset), 1 on later elements.
  - Selects are 0 when no tag is valid.
- Timing with accept at cycle 0, L = RD_LATENCY:
  - DOT: updates in cycles 1+L..N+L; res_valid first high at N+L+1.
  - SCALED: mac_reg_enable at 1+L; updates in 2+L..N+L+1; res_valid at N+L+2.
- Address arithmetic: wraps modulo 2^ADDR_W, e.g. base 1023 with N = 3 reads 1023, 0, 1.
- cmd_valid outside IDLE is ignored; the command is not queued.
- res_ready outside DONE has no effect.
- Saturation is handled inside MacUnit; this block does not inspect data.

Optional Feature:
MAC_SEQ_PERF_EN
- Defined: adds output perf_cycles (32 bits). It counts cycles from accept to the res_valid/res_ready handshake of the last command. It is updated at that handshake, held otherwise, and reset to 0. Counting saturates at 2^32-1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- DOT, N=4, x=[1.0,2.0,-1.0,0.5], w=[0.5,0.5,2.0,4.0], L=1 -> updates in cycles 2..5, loopback 0 only in cycle 2, res_valid at cycle 6, acc = 1.5; res_ready held low 3 cycles -> acc stable, cmd_ready=0.
- SCALED, N=3, x memory [k=2.0,1.0,-0.5,0.25], L=2 -> mac_reg_enable at cycle 3, updates in cycles 4..6 with x/w_select=0, w_rd_en never high, acc = 1.5.
- N=0 -> no reads, no mac strobes, res_valid and res_empty at cycle 1, acc unchanged.
- x_base=1022, w_base=1023, N=3 -> x_addr 1022,1023,0 and w_addr 1023,0,1; cmd_valid pulsed during ISSUE -> ignored, no second result.
- Reset asserted mid-ISSUE of N=8 -> all outputs 0 next edge and cmd_ready=1; new DOT N=2 then completes with correct sum and first loopback=0.
- MAC_SEQ_PERF_EN defined, DOT N=5, L=1, res_ready tied high -> perf_cycles = 7 after the handshake.

Source files
------------

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one MacUnit and its x/w operand memories through a DOT or SCALED vector command.
// Optional build macro MAC_SEQ_PERF_EN adds the perf_cycles output (cycles from accept to result handshake).
module mac_sequencer #(
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_x_base,
    input  logic [ADDR_W-1:0] cmd_w_base,
    output logic              x_rd_en,
    output logic [ADDR_W-1:0] x_addr,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic              mac_reg_enable,
    output logic              mac_x_select,
    output logic              mac_w_select,
    output logic              mac_acc_loopback,
    output logic              mac_acc_update,
    output logic              res_valid,
    output logic              res_empty,
    input  logic              res_ready,
`ifdef MAC_SEQ_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, LOAD_K, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic op_q, op_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [2:0] dcnt_q, dcnt_d;
    logic [2:0] tag_d, head;
    logic [RD_LATENCY-1:0][2:0] pipe_q, pipe_d;
    logic prod;
    logic cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic x_rd_en_q, x_rd_en_d, w_rd_en_q, w_rd_en_d;
    logic [ADDR_W-1:0] x_addr_q, x_addr_d, w_addr_q, w_addr_d;
    logic reg_en_q, reg_en_d, xsel_q, xsel_d, wsel_q, wsel_d, loop_q, loop_d, upd_q, upd_d;
    logic res_valid_q, res_valid_d, res_empty_q, res_empty_d;
`ifdef MAC_SEQ_PERF_EN
    logic [31:0] run_q, run_d, perf_q, perf_d;
`endif

    // Next state, read issue and tag generation; the tag {valid, first, kload} travels with each read
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        x_addr_d  = x_addr_q;
        w_addr_d  = w_addr_q;
        x_rd_en_d = 1'b0;
        w_rd_en_d = 1'b0;
        tag_d     = 3'b000;
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d     = cmd_op;
                cnt_d    = cmd_len - LEN_W'(1);
                x_addr_d = cmd_x_base;
                w_addr_d = cmd_w_base;
                if (cmd_len == '0) begin
                    state_d = DONE;
                end else begin
                    state_d   = cmd_op ? LOAD_K : ISSUE;
                    x_rd_en_d = 1'b1;
                    w_rd_en_d = ~cmd_op;
                    tag_d     = {1'b1, ~cmd_op, cmd_op};
                end
            end
            LOAD_K: begin
                state_d   = ISSUE;
                x_addr_d  = x_addr_q + ADDR_W'(1);
                x_rd_en_d = 1'b1;
                tag_d     = 3'b110;
            end
            ISSUE: if (cnt_q == '0) begin
                state_d = DRAIN;
                dcnt_d  = 3'(RD_LATENCY - 1);
            end else begin
                cnt_d     = cnt_q - LEN_W'(1);
                x_addr_d  = x_addr_q + ADDR_W'(1);
                w_addr_d  = w_addr_q + ADDR_W'(1);
                x_rd_en_d = 1'b1;
                w_rd_en_d = ~op_q;
                tag_d     = 3'b100;
            end
            DRAIN: if (dcnt_q == '0) state_d = DONE;
                   else dcnt_d = dcnt_q - 3'd1;
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
        busy_d      = state_d != IDLE;
        res_valid_d = state_d == DONE;
        res_empty_d = (state_d == DONE) && (state_q == IDLE || res_empty_q);
    end

    // Tag pipeline matching the memory read latency; the head decodes into next-cycle MacUnit strobes
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = tag_d;
        for (int j = 1; j < RD_LATENCY; j++) pipe_d[j] = pipe_q[j-1];
        head     = pipe_q[RD_LATENCY-1];
        prod     = head[2] & ~head[0];
        reg_en_d = head[2] & head[0];
        xsel_d   = prod & ~op_q;
        wsel_d   = prod & ~op_q;
        upd_d    = prod;
        loop_d   = prod & ~head[1];
    end

`ifdef MAC_SEQ_PERF_EN
    // Accept-to-handshake cycle counter, saturating, published at the result handshake
    always_comb begin
        run_d  = (state_q == IDLE) ? 32'd1 : (&run_q ? run_q : run_q + 32'd1);
        perf_d = (state_q == DONE && res_ready) ? run_q : perf_q;
    end
`endif

    // State and registered outputs; reset abandons any command and flushes in-flight tags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            pipe_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            x_rd_en_q   <= 1'b0;
            w_rd_en_q   <= 1'b0;
            x_addr_q    <= '0;
            w_addr_q    <= '0;
            reg_en_q    <= 1'b0;
            xsel_q      <= 1'b0;
            wsel_q      <= 1'b0;
            loop_q      <= 1'b0;
            upd_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_empty_q <= 1'b0;
`ifdef MAC_SEQ_PERF_EN
            run_q       <= '0;
            perf_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            pipe_q      <= pipe_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            x_rd_en_q   <= x_rd_en_d;
            w_rd_en_q   <= w_rd_en_d;
            x_addr_q    <= x_addr_d;
            w_addr_q    <= w_addr_d;
            reg_en_q    <= reg_en_d;
            xsel_q      <= xsel_d;
            wsel_q      <= wsel_d;
            loop_q      <= loop_d;
            upd_q       <= upd_d;
            res_valid_q <= res_valid_d;
            res_empty_q <= res_empty_d;
`ifdef MAC_SEQ_PERF_EN
            run_q       <= run_d;
            perf_q      <= perf_d;
`endif
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign busy             = busy_q;
    assign x_rd_en          = x_rd_en_q;
    assign w_rd_en          = w_rd_en_q;
    assign x_addr           = x_addr_q;
    assign w_addr           = w_addr_q;
    assign mac_reg_enable   = reg_en_q;
    assign mac_x_select     = xsel_q;
    assign mac_w_select     = wsel_q;
    assign mac_acc_loopback = loop_q;
    assign mac_acc_update   = upd_q;
    assign res_valid        = res_valid_q;
    assign res_empty        = res_empty_q;
`ifdef MAC_SEQ_PERF_EN
    assign perf_cycles      = perf_q;
`endif
endmodule
